mult8x8_pipe: RTL and testbench

- Unsigned 8x8 -> 16-bit multiplier, used as the partial-product building block of the CMAC 16-bit sign-magnitude multiplier.
- That multiplier uses four instances and sums their results.
- Two-stage registered pipeline with a valid qualifier.
- Optional compile-time approximate mode drops low-order partial-product columns for area/power savings.

---
 rtl/mult8x8_pipe_if.sv | 10 +
 rtl/mult8x8_pipe.sv | 47 ++++
 tb/tb_mult8x8_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mult8x8_pipe_if.sv
// mult8x8_pipe_if: operand/product bundle for the 8x8 pipelined multiplier
interface mult8x8_pipe_if;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic [15:0] out;
   modport master(output in_valid, a, b, input out_valid, out);
   modport slave(input in_valid, a, b, output out_valid, out);
endinterface

// File: rtl/mult8x8_pipe.sv
// mult8x8_pipe: unsigned 8x8->16 two-stage multiplier; MULT8X8_APPROX_EN drops low APPROX_COLS columns
module mult8x8_pipe #(
   parameter int APPROX_COLS = 4
) (
   input logic           clk,
   input logic           rst,
   mult8x8_pipe_if.slave m
);
`ifdef MULT8X8_APPROX_EN
   localparam int DROP = APPROX_COLS;
`else
   localparam int DROP = 0;
`endif
   logic [15:0] pp [8];
   logic [15:0] s_lo_d, s_hi_d, s_lo_q, s_hi_q, out_d, out_q;
   logic        v1_q, ov_q;
   // partial products, with bits in dropped columns forced to zero
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         pp[j] = '0;
         for (int i = 0; i < 8; i++)
            pp[j][i+j] = m.a[i] & m.b[j] & ((i + j) >= DROP);
      end
      s_lo_d = pp[0] + pp[1] + pp[2] + pp[3];
      s_hi_d = pp[4] + pp[5] + pp[6] + pp[7];
      out_d  = s_lo_q + s_hi_q;
   end
   // two register stages: half sums, then final sum; data holds when not valid
   always_ff @(posedge clk)
      if (rst) begin
         v1_q   <= 1'b0;
         s_lo_q <= '0;
         s_hi_q <= '0;
         ov_q   <= 1'b0;
         out_q  <= '0;
      end else begin
         v1_q <= m.in_valid;
         ov_q <= v1_q;
         if (m.in_valid) begin
            s_lo_q <= s_lo_d;
            s_hi_q <= s_hi_d;
         end
         if (v1_q) out_q <= out_d;
      end
   assign m.out       = out_q;
   assign m.out_valid = ov_q;
endmodule

// File: tb/tb_mult8x8_pipe.sv
// tb_mult8x8_pipe: randomized/directed self-checking bench for mult8x8_pipe
module tb_mult8x8_pipe;
   localparam int COLS = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   mult8x8_pipe_if bus();
   mult8x8_pipe #(.APPROX_COLS(COLS)) dut (.clk(clk), .rst(rst), .m(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
      int s;
`ifdef MULT8X8_APPROX_EN
      s = 0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (i + j >= COLS && a[i] && b[j]) s += 1 << (i + j);
`else
      s = int'(a) * int'(b);
`endif
      return 16'(s);
   endfunction
   task automatic chk(input string name, input logic ov, input logic [15:0] o);
      checks++;
      if (bus.out_valid !== ov || bus.out !== o) begin
         errors++;
         $display("FAIL %s: got valid=%b out=%h, expected valid=%b out=%h", name, bus.out_valid, bus.out, ov, o);
      end
   endtask
   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold: got valid=%b out=%h, expected valid=0 out=0000", bus.out_valid, bus.out);
         end
      end
      rst = 1'b0; bus.in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release: got valid=%b out=%h, expected valid=0 out=0000", bus.out_valid, bus.out);
         end
      end
   endtask
   task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      logic [15:0] prev;
      prev = bus.out;
      bus.in_valid = 1'b1; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== prev) begin
         errors++;
         $display("FAIL %s_early: got valid=%b out=%h, expected valid=0 out=%h", name, bus.out_valid, bus.out, prev);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp) begin
         errors++;
         $display("FAIL %s: got valid=%b out=%h, expected valid=1 out=%h", name, bus.out_valid, bus.out, exp);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== exp) begin
         errors++;
         $display("FAIL %s_pulse: got valid=%b out=%h, expected valid=0 out=%h", name, bus.out_valid, bus.out, exp);
      end
   endtask
   task automatic test_corners;
`ifdef MULT8X8_APPROX_EN
      run_one("approx_0f0f", 8'h0F, 8'h0F, 16'h00B0);
      run_one("approx_ffff", 8'hFF, 8'hFF, 16'hFDD0);
      run_one("approx_1001", 8'h10, 8'h01, 16'h0010);
`else
      run_one("corner_ffff", 8'hFF, 8'hFF, 16'hFE01);
      run_one("corner_00a5", 8'h00, 8'hA5, 16'h0000);
      run_one("corner_8002", 8'h80, 8'h02, 16'h0100);
      run_one("corner_01c3", 8'h01, 8'hC3, 16'h00C3);
`endif
   endtask
   task automatic test_stream(input string name, input int n, input int gap, input bit exhaustive);
      logic [15:0] exp [$];
      logic [7:0] a, b;
      for (int k = 0; k < n + 2 + gap; k++) begin
         if (k < n) begin
            a = exhaustive ? 8'(k >> 8) : 8'($urandom);
            b = exhaustive ? 8'(k) : 8'($urandom);
            bus.in_valid = 1'b1; bus.a = a; bus.b = b;
            exp.push_back(ref_prod(a, b));
         end else begin
            bus.in_valid = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
         end
         @(negedge clk);
         if (k >= 1 && k - 1 < n) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exp[k-1]) begin
               errors++;
               $display("FAIL %s[%0d]: got valid=%b out=%h, expected valid=1 out=%h", name, k - 1, bus.out_valid, bus.out, exp[k-1]);
            end
         end else if (k >= 1) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out !== exp[n-1]) begin
               errors++;
               $display("FAIL %s_gap: got valid=%b out=%h, expected valid=0 out=%h", name, bus.out_valid, bus.out, exp[n-1]);
            end
         end
      end
   endtask
   task automatic test_midflight_reset;
      bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL midflight_flush: got valid=%b out=%h, expected valid=0 out=0000", bus.out_valid, bus.out);
         end
      end
      run_one("after_reset", 8'h03, 8'h05, ref_prod(8'h03, 8'h05));
   endtask
   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
      test_reset;
      test_corners;
      test_stream("stream", 256, 3, 1'b0);
      test_midflight_reset;
      test_stream("exhaustive", 65536, 1, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
